// File: rtl/quadrature_encoder_emulator.sv
// Quadrature encoder emulator: emits A/B quadrature transitions at a commanded
// period, for a finite number of ticks or continuously, with position tracking.
module quadrature_encoder_emulator #(
    parameter int PERIOD_WIDTH = 16,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    stop,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_direction,
    input  logic [PERIOD_WIDTH-1:0] cmd_period,
    input  logic [COUNT_WIDTH-1:0]  cmd_steps,
    input  logic                    position_clear,
    output logic                    enc_a,
    output logic                    enc_b,
    output logic [COUNT_WIDTH-1:0]  position,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic                    r_dir;
    logic                    r_continuous;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [PERIOD_WIDTH-1:0] r_timer;
    logic [COUNT_WIDTH-1:0]  r_steps_rem;
    logic [1:0]              r_ab;
    logic [COUNT_WIDTH-1:0]  r_pos;
    logic                    r_done;

    logic                    w_accept;
    logic                    w_tick;
    logic                    w_last;
    logic [PERIOD_WIDTH-1:0] w_period_eff;
    logic [1:0]              w_ab_next;

    // A command offered while stop is high is never taken.
    assign w_accept     = cmd_valid & cmd_ready & ~stop;
    assign w_tick       = (r_state == ST_RUN) & enable & ~stop & ~w_accept &
                          (r_timer == PERIOD_WIDTH'(1));
    assign w_last       = w_tick & ~r_continuous & (r_steps_rem == COUNT_WIDTH'(1));
    assign w_period_eff = (cmd_period == '0) ? PERIOD_WIDTH'(1) : cmd_period;

    // Forward walks 00->10->11->01; reverse walks the same ring backwards.
    always_comb begin
        w_ab_next = r_ab;
        if (r_dir == 1'b0) begin
            w_ab_next = {~r_ab[0], r_ab[1]};
        end else begin
            w_ab_next = {r_ab[0], ~r_ab[1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (stop) begin
            w_state_next = ST_IDLE;
        end else if (w_accept) begin
            w_state_next = ST_RUN;
        end else if (w_last) begin
            w_state_next = ST_IDLE;
        end
    end

    always_comb begin
        busy      = (r_state == ST_RUN);
        cmd_ready = (r_state == ST_IDLE) | r_continuous;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir        <= 1'b0;
            r_continuous <= 1'b0;
            r_period     <= '0;
            r_timer      <= '0;
            r_steps_rem  <= '0;
            r_ab         <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_dir        <= cmd_direction;
                r_period     <= w_period_eff;
                r_timer      <= w_period_eff;
                r_steps_rem  <= cmd_steps;
                r_continuous <= (cmd_steps == '0);
            end else if ((r_state == ST_RUN) && enable && !stop) begin
                if (w_tick) begin
                    r_timer <= r_period;
                    r_ab    <= w_ab_next;
                    if (!r_continuous) begin
                        r_steps_rem <= r_steps_rem - COUNT_WIDTH'(1);
                    end
                end else begin
                    r_timer <= r_timer - PERIOD_WIDTH'(1);
                end
            end
            // A finished or stopped run must not leave continuous mode armed.
            if (w_last || (stop && !w_accept)) begin
                r_continuous <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || position_clear) begin
            r_pos <= '0;
        end else if (w_tick) begin
            r_pos <= r_dir ? (r_pos - COUNT_WIDTH'(1)) : (r_pos + COUNT_WIDTH'(1));
        end
    end

    assign enc_a    = r_ab[1];
    assign enc_b    = r_ab[0];
    assign position = r_pos;
    assign done     = r_done;

endmodule
